// File: rtl/gpu_pkg.sv
// Shared types and sizes for the palette stage of the pixel pipeline.
package gpu_pkg;

    localparam int INDEX_W         = 9;
    localparam int PAL_DEPTH       = 512;
    localparam int DEFAULT_COLOR_W = 8;

    // Last palette address; the clear sequencer stops here instead of wrapping.
    localparam logic [INDEX_W-1:0] LAST_ADDR = INDEX_W'(PAL_DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } pal_state_t;

endpackage

// File: rtl/palette_ram.sv
// Simple dual-port palette memory: one write port, one enabled synchronous
// read port. Read-first, so a same-address write is not seen by that read.
module palette_ram
    import gpu_pkg::*;
#(
    parameter int DEPTH  = PAL_DEPTH,
    parameter int ADDR_W = INDEX_W,
    parameter int DATA_W = DEFAULT_COLOR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: samples the old contents, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Palette lookup stage: maps the 9-bit background index to the final colour,
// keeps the syncs aligned with it and owns a sequencer that clears the palette.
module palette_lut
    import gpu_pkg::*;
#(
    parameter int                 COLOR_W       = DEFAULT_COLOR_W,
    parameter logic [COLOR_W-1:0] DEFAULT_COLOR = '0,
    parameter logic               SYNC_IDLE     = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    input  logic [INDEX_W-1:0] index_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               blank_in,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               clear_req,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               busy,
    output logic               wr_drop
);

    pal_state_t         state;
    pal_state_t         state_nx;
    logic [INDEX_W-1:0] clr_addr;
    logic [INDEX_W-1:0] clr_addr_nx;

    logic               ram_we;
    logic [INDEX_W-1:0] ram_waddr;
    logic [COLOR_W-1:0] ram_wdata;
    logic [COLOR_W-1:0] ram_rdata;

    logic               hsync_s1;
    logic               vsync_s1;
    logic               blank_s1;

    assign busy = (state == CLEAR);

    // Clear sequencer state; reset lands in CLEAR so the palette starts known.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nx;
            clr_addr <= clr_addr_nx;
        end
    end

    // Next-state logic: one address per clock, stop after the last entry.
    always_comb begin
        state_nx    = state;
        clr_addr_nx = clr_addr;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nx    = CLEAR;
                    clr_addr_nx = '0;
                end
            end
            CLEAR: begin
                if (clr_addr == LAST_ADDR) begin
                    state_nx = IDLE;
                end else begin
                    clr_addr_nx = clr_addr + INDEX_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Write-port mux: the sequencer owns the RAM while clearing, the CPU otherwise.
    always_comb begin
        ram_we    = wr_en;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (busy) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = DEFAULT_COLOR;
        end
    end

    // Flag CPU writes that arrived while the sequencer held the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= busy && wr_en;
        end
    end

    palette_ram #(
        .DEPTH  (PAL_DEPTH),
        .ADDR_W (INDEX_W),
        .DATA_W (COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (pix_en),
        .raddr (index_in),
        .rdata (ram_rdata)
    );

    // Stage 1 sideband: travels with the RAM read so all stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_s1 <= SYNC_IDLE;
            vsync_s1 <= SYNC_IDLE;
            blank_s1 <= 1'b1;
        end else if (pix_en) begin
            hsync_s1 <= hsync_in;
            vsync_s1 <= vsync_in;
            blank_s1 <= blank_in;
        end
    end

    // Stage 2 output registers: colour is forced black when blanked or clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= '0;
            hsync_out <= SYNC_IDLE;
            vsync_out <= SYNC_IDLE;
        end else if (pix_en) begin
            rgb_out   <= (blank_s1 || busy) ? '0 : ram_rdata;
            hsync_out <= hsync_s1;
            vsync_out <= vsync_s1;
        end
    end

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: reset clear, lookups, strobing, clear
// interaction with CPU writes, read-first collisions and mid-clear reset.
module tb_palette_lut;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [8:0] index_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       blank_in;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic       clear_req;
    logic [7:0] rgb_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       busy;
    logic       wr_drop;

    int total = 0;
    int bad   = 0;

    palette_lut dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_en    (pix_en),
        .index_in  (index_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .blank_in  (blank_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear_req (clear_req),
        .rgb_out   (rgb_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .busy      (busy),
        .wr_drop   (wr_drop)
    );

    // 100 MHz pixel clock.
    always #5 clk = ~clk;

    // Hard stop in case something never settles.
    initial begin
        #1ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pe, input logic [8:0] idx,
                                 input logic hs, input logic vs, input logic blk);
        pix_en   = pe;
        index_in = idx;
        hsync_in = hs;
        vsync_in = vs;
        blank_in = blk;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Counts clock edges until busy falls, bounded so a stuck sequencer ends the run.
    task automatic countBusy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 600);
    endtask

    logic [7:0] hpat;
    logic [7:0] vpat;
    logic [8:0] idx3 [5];
    logic       blk3 [5];
    logic [7:0] exp3 [4];
    logic [7:0] rgb_acc;
    int         n;
    int         drops;

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;
        applyStimulus(1'b1, 9'd0, 1'b1, 1'b1, 1'b0);

        // ---- 1: reset values and the power-up clear ----
        tick();
        tick();
        checkOutput("rst_rgb",   16'(rgb_out),   16'h00);
        checkOutput("rst_hsync", 16'(hsync_out), 16'h1);
        checkOutput("rst_vsync", 16'(vsync_out), 16'h1);
        checkOutput("rst_busy",  16'(busy),      16'h1);
        checkOutput("rst_drop",  16'(wr_drop),   16'h0);

        rst_n   = 1'b1;
        rgb_acc = '0;
        n       = 0;
        do begin
            tick();
            n++;
            rgb_acc |= rgb_out;
        end while (busy && n < 600);
        checkOutput("init_busy_len", 16'(n), 16'd512);
        checkOutput("init_rgb_zero", 16'(rgb_acc), 16'h00);

        rgb_acc = '0;
        for (int i = 0; i <= 512; i++) begin
            applyStimulus(1'b1, 9'(i % 512), 1'b1, 1'b1, 1'b0);
            tick();
            if (i >= 1) rgb_acc |= rgb_out;
        end
        tick();
        rgb_acc |= rgb_out;
        checkOutput("init_all_zero", 16'(rgb_acc), 16'h00);

        // ---- 2: CPU write then lookup, sync delay ----
        wr_en = 1'b1; wr_addr = 9'h005; wr_data = 8'hE3;
        tick();
        wr_addr = 9'h006; wr_data = 8'h1C;
        tick();
        wr_en = 1'b0;
        checkOutput("idle_no_drop", 16'(wr_drop), 16'h0);

        applyStimulus(1'b1, 9'd5, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 9'd0, 1'b1, 1'b1, 1'b0);
        checkOutput("lookup_not_early", 16'(rgb_out), 16'h00);
        tick();
        checkOutput("lookup_5", 16'(rgb_out), 16'hE3);

        hpat = 8'b1110_0011;
        vpat = 8'b1101_1111;
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b1, 9'd0, hpat[j], vpat[j], 1'b0);
            tick();
            if (j >= 2) begin
                checkOutput($sformatf("hsync_d%0d", j), 16'(hsync_out), 16'(hpat[j-1]));
                checkOutput($sformatf("vsync_d%0d", j), 16'(vsync_out), 16'(vpat[j-1]));
            end
        end
        applyStimulus(1'b1, 9'd0, 1'b1, 1'b1, 1'b0);
        tick();
        tick();

        // ---- 3: strobe every second clock, with one blanked pixel ----
        idx3 = '{9'd5, 9'd6, 9'd5, 9'd5, 9'd0};
        blk3 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp3 = '{8'hE3, 8'h1C, 8'hE3, 8'h00};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, idx3[k], 1'b1, 1'b1, blk3[k]);
            tick();
            if (k >= 1) checkOutput($sformatf("strobe_px%0d", k - 1), 16'(rgb_out), 16'(exp3[k-1]));
            applyStimulus(1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0);
            tick();
            if (k >= 1) checkOutput($sformatf("hold_px%0d", k - 1), 16'(rgb_out), 16'(exp3[k-1]));
        end

        // ---- 4: clear with a dropped write and an ignored second request ----
        applyStimulus(1'b1, 9'd5, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("pre_clear_5", 16'(rgb_out), 16'hE3);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        checkOutput("clear_busy_rise", 16'(busy), 16'h1);
        rgb_acc = '0;
        drops   = 0;
        n       = 0;
        do begin
            if (n == 10) begin
                wr_en = 1'b1; wr_addr = 9'd7; wr_data = 8'h55;
            end
            if (n == 100) clear_req = 1'b1;
            tick();
            wr_en     = 1'b0;
            clear_req = 1'b0;
            n++;
            rgb_acc |= rgb_out;
            if (wr_drop) drops++;
        end while (busy && n < 600);
        checkOutput("clear_busy_len", 16'(n), 16'd512);
        checkOutput("clear_drops", 16'(drops), 16'd1);
        checkOutput("clear_rgb_black", 16'(rgb_acc), 16'h00);

        applyStimulus(1'b1, 9'd7, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 9'd5, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("after_clear_7", 16'(rgb_out), 16'h00);
        tick();
        checkOutput("after_clear_5", 16'(rgb_out), 16'h00);

        // ---- 5: read-first on a same-address collision ----
        applyStimulus(1'b1, 9'd9, 1'b1, 1'b1, 1'b0);
        wr_en = 1'b1; wr_addr = 9'd9; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        tick();
        checkOutput("rdw_old", 16'(rgb_out), 16'h00);
        tick();
        checkOutput("rdw_new", 16'(rgb_out), 16'hFF);

        // ---- 6: reset in the middle of a clear ----
        applyStimulus(1'b1, 9'd0, 1'b0, 1'b0, 1'b0);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (n < 300) begin
            if (n == 299) begin
                wr_en = 1'b1; wr_addr = 9'd3; wr_data = 8'hAA;
            end
            tick();
            wr_en = 1'b0;
            n++;
        end
        checkOutput("mid_drop",  16'(wr_drop),   16'h1);
        checkOutput("mid_hsync", 16'(hsync_out), 16'h0);
        checkOutput("mid_vsync", 16'(vsync_out), 16'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_rgb",   16'(rgb_out),   16'h00);
        checkOutput("arst_hsync", 16'(hsync_out), 16'h1);
        checkOutput("arst_vsync", 16'(vsync_out), 16'h1);
        checkOutput("arst_busy",  16'(busy),      16'h1);
        checkOutput("arst_drop",  16'(wr_drop),   16'h0);
        tick();
        tick();
        applyStimulus(1'b1, 9'd0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        countBusy(n);
        checkOutput("rerst_busy_len", 16'(n), 16'd512);

        applyStimulus(1'b1, 9'd9, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 9'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("rerst_9_cleared", 16'(rgb_out), 16'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
